// File: rtl/ram16_arbiter.sv
// ram16_arbiter: round-robin arbiter and sequencer between an instruction
// fetch port (read-only) and a data load/store port, in front of a
// byte-addressed big-endian 16-bit RAM with combinational read and a
// posedge write gated by en. One RAM transaction at a time. Each transaction
// is latched in IDLE, runs for exactly one ACCESS cycle, and is completed
// by a registered one-cycle ack to its owner.
module ram16_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned MAX_ADDR   = (1 << ADDR_WIDTH) - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction fetch port
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_ack,
  output logic [WORD_WIDTH-1:0] f_rdata,
  output logic                  f_err,
  // data load/store port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WORD_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [WORD_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  // RAM side
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [WORD_WIDTH-1:0] ram_read_data,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [WORD_WIDTH-1:0] ram_write_data,
  output logic                  ram_en
);

  // A word access starting at the last byte address would need a byte past the end.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_ADDR);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  state_e                state_q,      state_d;
  owner_e                owner_q,      owner_d;
  owner_e                last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
  logic [WORD_WIDTH-1:0] wdata_q,      wdata_d;
  logic                  we_q,         we_d;
  logic                  f_ack_q,      f_ack_d;
  logic                  d_ack_q,      d_ack_d;
  logic                  f_err_q,      f_err_d;
  logic                  d_err_q,      d_err_d;
  logic [WORD_WIDTH-1:0] f_rdata_q,    f_rdata_d;
  logic [WORD_WIDTH-1:0] d_rdata_q,    d_rdata_d;

  logic   illegal;
  owner_e winner;

  assign illegal = (addr_q == LAST_ADDR);

  // Round-robin pick: a lone requester wins; on a tie the port not granted last time wins.
  always_comb begin
    winner = OWN_F;
    if (f_req && d_req) begin
      winner = (last_grant_q == OWN_D) ? OWN_F : OWN_D;
    end else if (d_req) begin
      winner = OWN_D;
    end
  end

  // Next-state, transaction latch and completion logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    f_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    f_err_d      = 1'b0;
    d_err_d      = 1'b0;
    f_rdata_d    = f_rdata_q;
    d_rdata_d    = d_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (f_req || d_req) begin
          owner_d      = winner;
          last_grant_d = winner;
          state_d      = ST_ACCESS;
          if (winner == OWN_F) begin
            addr_d  = f_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end else begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end
        end
      end

      ST_ACCESS: begin
        state_d = ST_IDLE;
        if (owner_q == OWN_F) begin
          f_ack_d = 1'b1;
          f_err_d = illegal;
          if (!illegal && !we_q) begin
            f_rdata_d = ram_read_data;
          end
        end else begin
          d_ack_d = 1'b1;
          d_err_d = illegal;
          if (!illegal && !we_q) begin
            d_rdata_d = ram_read_data;
          end
        end
      end
    endcase
  end

  // State register with synchronous reset; last_grant resets to D so F wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_F;
      last_grant_q <= OWN_D;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      f_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      f_err_q      <= 1'b0;
      d_err_q      <= 1'b0;
      f_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      f_ack_q      <= f_ack_d;
      d_ack_q      <= d_ack_d;
      f_err_q      <= f_err_d;
      d_err_q      <= d_err_d;
      f_rdata_q    <= f_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // rst gates ram_en combinationally so a reset during ACCESS cannot land a write.
  assign ram_en         = (state_q == ST_ACCESS) && we_q && !illegal && !rst;
  assign ram_read_addr  = addr_q;
  assign ram_write_addr = addr_q;
  assign ram_write_data = wdata_q;

  assign f_ack   = f_ack_q;
  assign d_ack   = d_ack_q;
  assign f_err   = f_err_q;
  assign d_err   = d_err_q;
  assign f_rdata = f_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_ram16_arbiter.sv
// Self-checking bench for ram16_arbiter with a behavioural big-endian RAM.
module tb_ram16_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned WW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_ack;
  logic [WW-1:0] f_rdata;
  logic          f_err;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [WW-1:0] d_wdata;
  logic          d_ack;
  logic [WW-1:0] d_rdata;
  logic          d_err;
  logic [AW-1:0] ram_read_addr;
  logic [WW-1:0] ram_read_data;
  logic [AW-1:0] ram_write_addr;
  logic [WW-1:0] ram_write_data;
  logic          ram_en;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram16_arbiter #(
    .ADDR_WIDTH(AW),
    .WORD_WIDTH(WW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .f_req         (f_req),
    .f_addr        (f_addr),
    .f_ack         (f_ack),
    .f_rdata       (f_rdata),
    .f_err         (f_err),
    .d_req         (d_req),
    .d_we          (d_we),
    .d_addr        (d_addr),
    .d_wdata       (d_wdata),
    .d_ack         (d_ack),
    .d_rdata       (d_rdata),
    .d_err         (d_err),
    .ram_read_addr (ram_read_addr),
    .ram_read_data (ram_read_data),
    .ram_write_addr(ram_write_addr),
    .ram_write_data(ram_write_data),
    .ram_en        (ram_en)
  );

  // Behavioural RAM: combinational big-endian read, posedge write gated by en.
  logic [7:0]  mem [0:65535];
  logic        poke_en = 1'b0;
  logic [15:0] poke_a  = '0;
  logic [7:0]  poke_d  = '0;
  logic [15:0] rd_a1;
  logic [15:0] wr_a1;
  int          en_cnt = 0;

  assign rd_a1         = ram_read_addr + 16'd1;
  assign wr_a1         = ram_write_addr + 16'd1;
  assign ram_read_data = {mem[ram_read_addr], mem[rd_a1]};

  always @(posedge clk) begin
    if (poke_en) begin
      mem[poke_a] <= poke_d;
    end else if (ram_en) begin
      mem[ram_write_addr] <= ram_write_data[15:8];
      mem[wr_a1]          <= ram_write_data[7:0];
    end
    if (ram_en) en_cnt <= en_cnt + 1;
  end

  // Transaction-level reference model.
  logic [7:0]  ref_mem [0:65535];
  bit          ref_last_d;
  logic [15:0] ref_f_rdata;
  logic [15:0] ref_d_rdata;

  function automatic logic [15:0] ref_word(input logic [15:0] a);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return {ref_mem[a], ref_mem[a1]};
  endfunction

  task automatic model_txn(input bit is_d, input bit we, input logic [15:0] a,
                           input logic [15:0] wd, output bit err, output int en);
    logic [15:0] a1;
    a1  = a + 16'd1;
    err = (a == 16'hFFFF);
    en  = 0;
    if (!err) begin
      if (we) begin
        ref_mem[a]  = wd[15:8];
        ref_mem[a1] = wd[7:0];
        en          = 1;
      end else if (is_d) begin
        ref_d_rdata = ref_word(a);
      end else begin
        ref_f_rdata = ref_word(a);
      end
    end
    ref_last_d = is_d;
  endtask

  task automatic chk(input string grp, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", grp, what, act, exp);
    end
  endtask

  // Entered and left on a negedge.
  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    poke_en    = 1'b1;
    poke_a     = a;
    poke_d     = d;
    ref_mem[a] = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    f_req = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst         = 1'b0;
    ref_last_d  = 1'b1;
    ref_f_rdata = '0;
    ref_d_rdata = '0;
  endtask

  function automatic logic [15:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 16'hFFFF;
    if (r == 1) return 16'hFFFE;
    return 16'($urandom_range(0, 126));
  endfunction

  // One single-port transaction with fixed latency; entered and left on a negedge.
  task automatic run_one(input string nm, input bit is_d, input bit we,
                         input logic [15:0] a, input logic [15:0] wd,
                         input logic [15:0] exp_rd, input bit exp_err, input int exp_en);
    int en0;
    en0 = en_cnt;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    end else begin
      f_req = 1'b1; f_addr = a;
    end
    @(negedge clk);
    chk(nm, "ack_in_access", 32'({f_ack, d_ack}), 32'd0);
    @(negedge clk);
    if (is_d) begin
      d_req = 1'b0; d_we = 1'b0;
    end else begin
      f_req = 1'b0;
    end
    chk(nm, "acks", 32'({f_ack, d_ack}), is_d ? 32'd1 : 32'd2);
    chk(nm, "err", 32'(is_d ? d_err : f_err), 32'(exp_err));
    chk(nm, "rdata", 32'(is_d ? d_rdata : f_rdata), 32'(exp_rd));
    chk(nm, "ram_en_cycles", 32'(en_cnt - en0), 32'(exp_en));
  endtask

  typedef struct {
    string       nm;
    bit          is_d;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    bit          exp_err;
    int          exp_en;
  } vec_t;

  vec_t        vt[8];
  logic [15:0] hold_exp[3];

  initial begin
    bit          pf, pd, dwe, win_d, exp_err;
    logic [15:0] fa, da, dwd;
    int          exp_en, en0, bad;

    rst = 1'b1; f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    vt[0] = '{"fetch10",  1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0, 0};
    vt[1] = '{"store21",  1'b1, 1'b1, 16'h0021, 16'hBEEF, 16'h0000, 1'b0, 1};
    vt[2] = '{"load21",   1'b1, 1'b0, 16'h0021, 16'h0000, 16'hBEEF, 1'b0, 0};
    vt[3] = '{"fetch21",  1'b0, 1'b0, 16'h0021, 16'h0000, 16'hBEEF, 1'b0, 0};
    vt[4] = '{"storeFFFF",1'b1, 1'b1, 16'hFFFF, 16'hAAAA, 16'hBEEF, 1'b1, 0};
    vt[5] = '{"fetchFFFF",1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hBEEF, 1'b1, 0};
    vt[6] = '{"fetch11",  1'b0, 1'b0, 16'h0011, 16'h0000, 16'h3456, 1'b0, 0};
    vt[7] = '{"loadFFFE", 1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h9ABC, 1'b0, 0};
    hold_exp[0] = 16'h1122;
    hold_exp[1] = 16'h3344;
    hold_exp[2] = 16'h5566;

    // Reset values, sampled while rst is still asserted.
    @(negedge clk);
    @(negedge clk);
    chk("reset", "acks",      32'({f_ack, d_ack}), 32'd0);
    chk("reset", "errs",      32'({f_err, d_err}), 32'd0);
    chk("reset", "f_rdata",   32'(f_rdata), 32'd0);
    chk("reset", "d_rdata",   32'(d_rdata), 32'd0);
    chk("reset", "ram_en",    32'(ram_en), 32'd0);
    chk("reset", "ram_waddr", 32'(ram_write_addr), 32'd0);
    chk("reset", "ram_wdata", 32'(ram_write_data), 32'd0);
    rst = 1'b0;

    poke(16'h0010, 8'h12); poke(16'h0011, 8'h34); poke(16'h0012, 8'h56);
    poke(16'hFFFE, 8'h9A); poke(16'hFFFF, 8'hBC);
    poke(16'h0000, 8'h11); poke(16'h0001, 8'h22); poke(16'h0002, 8'h33);
    poke(16'h0003, 8'h44); poke(16'h0004, 8'h55); poke(16'h0005, 8'h66);
    poke(16'h0040, 8'hC3); poke(16'h0041, 8'h3C);

    for (int i = 0; i < 8; i++) begin
      run_one(vt[i].nm, vt[i].is_d, vt[i].we, vt[i].addr, vt[i].wdata,
              vt[i].exp_rdata, vt[i].exp_err, vt[i].exp_en);
    end
    chk("store21",   "mem21",   32'(mem[16'h0021]), 32'h00BE);
    chk("store21",   "mem22",   32'(mem[16'h0022]), 32'h00EF);
    chk("storeFFFF", "memFFFF", 32'(mem[16'hFFFF]), 32'h00BC);
    chk("storeFFFF", "mem0000", 32'(mem[16'h0000]), 32'h0011);

    // d_req held across ack cycles, address advanced in each ack cycle.
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0000;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("hold", "d_ack", 32'(d_ack), 32'((k % 2) == 0));
      chk("hold", "f_ack", 32'(f_ack), 32'd0);
      if ((k % 2) == 0) begin
        chk("hold", "d_rdata", 32'(d_rdata), 32'(hold_exp[k/2 - 1]));
        d_addr = 16'(2 * (k / 2));
        if (k == 6) d_req = 1'b0;
      end
    end

    // Reset during the ACCESS cycle of a store.
    en0 = en_cnt;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'h5555;
    @(negedge clk);
    chk("rstmid", "en_in_access", 32'(ram_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid", "en_forced_low", 32'(ram_en), 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid", "acks",      32'({f_ack, d_ack}), 32'd0);
    chk("rstmid", "errs",      32'({f_err, d_err}), 32'd0);
    chk("rstmid", "f_rdata",   32'(f_rdata), 32'd0);
    chk("rstmid", "d_rdata",   32'(d_rdata), 32'd0);
    chk("rstmid", "ram_waddr", 32'(ram_write_addr), 32'd0);
    chk("rstmid", "ram_wdata", 32'(ram_write_data), 32'd0);
    @(negedge clk);
    chk("rstmid", "no_late_ack", 32'({f_ack, d_ack}), 32'd0);
    chk("rstmid", "mem40", 32'(mem[16'h0040]), 32'h00C3);
    chk("rstmid", "mem41", 32'(mem[16'h0041]), 32'h003C);
    chk("rstmid", "en_cycles", 32'(en_cnt - en0), 32'd0);

    // Contention straight after reset: F wins first, then grants alternate.
    f_req = 1'b1; f_addr = 16'h0010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'hFFFE;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("contend", "f_ack", 32'(f_ack), 32'(k == 2 || k == 6));
      chk("contend", "d_ack", 32'(d_ack), 32'(k == 4 || k == 8));
      if (k == 2 || k == 6) chk("contend", "f_rdata", 32'(f_rdata), 32'h1234);
      if (k == 4 || k == 8) chk("contend", "d_rdata", 32'(d_rdata), 32'h9ABC);
      if (k == 8) begin
        f_req = 1'b0; d_req = 1'b0;
      end
    end

    // Randomized traffic against the reference model.
    for (int a = 0; a < 128; a++) poke(16'(a), 8'($urandom_range(0, 255)));
    poke(16'hFFFE, 8'($urandom_range(0, 255)));
    poke(16'hFFFF, 8'($urandom_range(0, 255)));
    do_reset();
    pf = 1'b0; pd = 1'b0; dwe = 1'b0;
    fa = '0; da = '0; dwd = '0;
    for (int it = 0; it < 300; it++) begin
      if (!pf && $urandom_range(0, 2) != 0) begin
        pf = 1'b1; fa = rand_addr();
      end else if (pf && $urandom_range(0, 3) == 0) begin
        fa = rand_addr();
      end
      if (!pd && $urandom_range(0, 2) != 0) begin
        pd = 1'b1; da = rand_addr(); dwe = 1'($urandom_range(0, 1));
        dwd = 16'($urandom_range(0, 65535));
      end else if (pd && $urandom_range(0, 3) == 0) begin
        da = rand_addr(); dwe = 1'($urandom_range(0, 1));
        dwd = 16'($urandom_range(0, 65535));
      end
      f_req = pf; f_addr = fa;
      d_req = pd; d_we = dwe; d_addr = da; d_wdata = dwd;
      if (!pf && !pd) begin
        @(negedge clk);
        chk("rand", "idle_acks", 32'({f_ack, d_ack}), 32'd0);
      end else begin
        win_d = (pf && pd) ? !ref_last_d : pd;
        en0   = en_cnt;
        model_txn(win_d, win_d ? dwe : 1'b0, win_d ? da : fa, win_d ? dwd : 16'h0000,
                  exp_err, exp_en);
        @(negedge clk);
        chk("rand", "ack_in_access", 32'({f_ack, d_ack}), 32'd0);
        @(negedge clk);
        chk("rand", "acks", 32'({f_ack, d_ack}), win_d ? 32'd1 : 32'd2);
        chk("rand", "f_err", 32'(f_err), 32'(!win_d && exp_err));
        chk("rand", "d_err", 32'(d_err), 32'(win_d && exp_err));
        chk("rand", "f_rdata", 32'(f_rdata), 32'(ref_f_rdata));
        chk("rand", "d_rdata", 32'(d_rdata), 32'(ref_d_rdata));
        chk("rand", "ram_en_cycles", 32'(en_cnt - en0), 32'(exp_en));
        if (win_d) pd = 1'b0;
        else       pf = 1'b0;
      end
    end
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    bad = 0;
    for (int a = 0; a < 128; a++) if (mem[16'(a)] !== ref_mem[16'(a)]) bad++;
    if (mem[16'hFFFE] !== ref_mem[16'hFFFE]) bad++;
    if (mem[16'hFFFF] !== ref_mem[16'hFFFF]) bad++;
    chk("rand", "mem_bad_bytes", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram16_arbiter.md
Name: ram16_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 16-bit byte-addressed RAM (big-endian word = mem[a] high byte, mem[a+1] low byte; combinational read; posedge write gated by en).
- Port F (instruction fetch) is read-only; port D (data load/store) reads and writes.
- Round-robin arbitration; one RAM transaction at a time; one registered ack per transaction.
- Sits between the CPU front-end/LSU and the RAM instance.

Parameters:
- ADDR_WIDTH, 16, byte address width; must match the RAM's.
- WORD_WIDTH, 16, data word width; must match the RAM's.
- MAX_ADDR, (1<<ADDR_WIDTH)-1, highest byte address; a word access starting here is illegal (the second byte is out of range).

Ports:
- clk  in  1  system clock; all state updates on the posedge.
- rst  in  1  synchronous, active-high reset.
- f_req  in  1  fetch request, level; hold until f_ack.
- f_addr  in  ADDR_WIDTH  fetch byte address.
- f_ack  out  1  one-cycle pulse when the fetch completes.
- f_rdata  out  WORD_WIDTH  fetched word; valid with f_ack, held until the next f_ack.
- f_err  out  1  pulses with f_ack if the access was illegal.
- d_req  in  1  data request, level; hold until d_ack.
- d_we  in  1  1 = store, 0 = load; sampled with d_req.
- d_addr  in  ADDR_WIDTH  data byte address.
- d_wdata  in  WORD_WIDTH  store data.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  WORD_WIDTH  load result; valid with d_ack, held until the next d_ack; unchanged by stores.
- d_err  out  1  pulses with d_ack if the access was illegal.
- ram_read_addr  out  ADDR_WIDTH  to RAM read_addr.
- ram_read_data  in  WORD_WIDTH  from RAM read_data.
- ram_write_addr  out  ADDR_WIDTH  to RAM write_addr.
- ram_write_data  out  WORD_WIDTH  to RAM write_data.
- ram_en  out  1  to RAM en.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, f_ack=d_ack=f_err=d_err=0, f_rdata=d_rdata=0, last_grant=D (so F wins the first tie). Latched addr, wdata, we and owner are all cleared to 0.
- FSM has two states, IDLE and ACCESS.
- IDLE, at a posedge:
  - If any req is high, pick the owner and latch addr/we/wdata from that port. For F, we=0 and wdata=0. Go to ACCESS.
  - If nothing is requested, stay in IDLE.
- Arbitration:
  - Only one port requesting: that port wins.
  - Both requesting: the port that is not last_grant wins.
  - last_grant is updated to the winner at the latch edge.
- ACCESS (exactly one cycle), combinational outputs:
  - ram_read_addr = ram_write_addr = latched addr.
  - ram_write_data = latched wdata.
  - ram_en = latched we AND NOT illegal AND NOT rst.
- ACCESS, at the posedge:
  - Pulse the owner's ack for the following cycle.
  - On a legal read, capture ram_read_data into the owner's rdata.
  - Set the owner's err = illegal.
  - Return to IDLE.
- Outside ACCESS: ram_en=0; RAM address and data outputs hold their latched values.
- Illegal access: latched addr == MAX_ADDR.
  - No write is issued and rdata is not updated.
  - Ack and err pulse together.
  - Odd addresses are otherwise legal.
- Latency: req sampled at edge N → ACCESS during cycle N+1 → ack high during cycle N+2.
- Throughput: one transaction per 2 cycles.
- Requester rule: the requester drops req during its ack cycle unless it has a further access.
  - A req still high at the edge that ends the ack cycle is treated as a new request.
  - The arbiter is in IDLE during every ack cycle, so back-to-back requests are accepted.
- Request changes: a change to addr/we/wdata while req is held but not yet granted takes effect; the values are sampled only at the latch edge.
- Stores: the write lands at the posedge ending ACCESS. A following read from any port sees the new data.
- Reset mid-ACCESS: ram_en is forced low in that same cycle, so no partial write. No ack is issued and state goes to IDLE.
- Simultaneous f_req and d_req on consecutive transactions with round-robin priority: the grants alternate F, D, F, D.

Test Plan:
- Reset, then a single fetch: f_req=1, f_addr=0x0010, RAM bytes 0x12,0x34 → f_ack exactly 2 cycles after the req edge, f_rdata=0x1234, f_err=0, ram_en never high.
- Store then load: d_we=1, d_addr=0x0021, d_wdata=0xBEEF, then d_we=0 at the same address → mem[0x21]=0xBE, mem[0x22]=0xEF, ram_en high exactly one cycle, d_rdata=0xBEEF; a later f_addr=0x0021 returns 0xBEEF.
- Contention: f_req and d_req held high for 4 transactions → grant order F,D,F,D; acks at cycles 2,4,6,8; each rdata matches its own port's address.
- Illegal store: d_we=1, d_addr=0xFFFF, d_wdata=0xAAAA → d_ack and d_err pulse together, ram_en stays 0, mem[0xFFFF] and mem[0x0000] unchanged, d_rdata unchanged.
- Reset mid-ACCESS of a store to 0x0040 with 0x5555 → mem[0x40..0x41] unchanged, no d_ack, all outputs at reset values the next cycle.
- Hold across ack: d_req held high for 3 loads at 0x0000/0x0002/0x0004 (address changed in each ack cycle) → 3 d_acks spaced 2 cycles apart, data correct in order.
